tone_classifier: RTL and testbench

TONE_CLASSIFIER -- requirements
Module: tone_classifier

---
 rtl/tone_pkg.sv | 20 ++
 rtl/tone_sync.sv | 29 ++
 rtl/tone_classifier.sv | 155 +++++++++++++++
 tb/tb_tone_classifier.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants and helpers for the tone classifier: direction code mapping and width helpers.
// Consumers map direction codes to motion themselves; nothing about motion lives here.
package tone_pkg;

    localparam int TD_HOLD = 0;

    function automatic int dir_w(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction

    function automatic int gap_w(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

    // Channel i reports as code i+1 so that code 0 stays free for HOLD.
    function automatic int ch_code(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/tone_sync.sv
// Single-bit multi-flop synchroniser for asynchronous detector and button inputs.
// All stages clear on the synchronous reset.
module tone_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tone_classifier.sv
// Priority tone/button classifier: synchronises each channel, picks the lowest-index active
// channel and commits its direction code once it has won DWELL cycles, tolerating GAP-cycle dropouts.
module tone_classifier
    import tone_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int DWELL       = 25_000_000,
    parameter int CNT_W       = 26,
    parameter int GAP         = 0,
    parameter int SYNC_STAGES = 2,
    localparam int DIR_W      = dir_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] raw_tone,
    input  logic [NUM_CH-1:0] btn,
    output logic [DIR_W-1:0]  tone_dir,
    output logic              dir_valid,
    output logic              dir_changed,
    output logic [CNT_W-1:0]  winner_cnt
);

    localparam int               GAP_W     = gap_w(GAP);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP);
    localparam logic [DIR_W-1:0] CODE_HOLD = DIR_W'(TD_HOLD);

    logic [NUM_CH-1:0] sync_tone;
    logic [NUM_CH-1:0] sync_btn;
    logic [NUM_CH-1:0] req;

    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [GAP_W-1:0] gap_q [NUM_CH];
    logic [GAP_W-1:0] gap_d [NUM_CH];

    logic [DIR_W-1:0] tone_dir_q;
    logic [DIR_W-1:0] tone_dir_d;
    logic             dir_valid_q;
    logic             dir_valid_d;
    logic             dir_changed_q;
    logic             dir_changed_d;

    logic [NUM_CH-1:0] win_onehot;
    logic [DIR_W-1:0]  win_code;
    logic [CNT_W-1:0]  win_cnt;
    logic              any_req;
    logic              commit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_sync
            tone_sync #(
                .STAGES (SYNC_STAGES)
            ) u_tone_sync (
                .clk (clk),
                .rst (rst),
                .d   (raw_tone[gi]),
                .q   (sync_tone[gi])
            );

            tone_sync #(
                .STAGES (SYNC_STAGES)
            ) u_btn_sync (
                .clk (clk),
                .rst (rst),
                .d   (btn[gi]),
                .q   (sync_btn[gi])
            );
        end
    endgenerate

    assign req = sync_tone | sync_btn;

    // Scan from the top so the lowest active index is the last one written and wins.
    always_comb begin
        win_onehot = '0;
        win_code   = CODE_HOLD;
        win_cnt    = '0;
        any_req    = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_code      = DIR_W'(ch_code(i));
                win_cnt       = cnt_q[i];
                any_req       = 1'b1;
            end
        end
    end

    assign commit = enable && any_req && (win_cnt == CNT_LAST);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            gap_d[i] = gap_q[i];
            if (!enable || commit) begin
                cnt_d[i] = '0;
                gap_d[i] = '0;
            end else if (win_onehot[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                gap_d[i] = '0;
            end else if (cnt_q[i] != '0) begin
                // A pre-empted or dropped channel keeps its count until the gap budget runs out.
                if (gap_q[i] == GAP_LIMIT) begin
                    cnt_d[i] = '0;
                    gap_d[i] = '0;
                end else begin
                    gap_d[i] = gap_q[i] + GAP_W'(1);
                end
            end
        end
    end

    always_comb begin
        tone_dir_d    = tone_dir_q;
        dir_valid_d   = 1'b0;
        dir_changed_d = 1'b0;
        if (!enable) begin
            tone_dir_d = CODE_HOLD;
        end else if (commit) begin
            tone_dir_d    = win_code;
            dir_valid_d   = 1'b1;
            dir_changed_d = (win_code != tone_dir_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tone_dir_q    <= CODE_HOLD;
            dir_valid_q   <= 1'b0;
            dir_changed_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                gap_q[i] <= '0;
            end
        end else begin
            tone_dir_q    <= tone_dir_d;
            dir_valid_q   <= dir_valid_d;
            dir_changed_q <= dir_changed_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                gap_q[i] <= gap_d[i];
            end
        end
    end

    assign tone_dir    = tone_dir_q;
    assign dir_valid   = dir_valid_q;
    assign dir_changed = dir_changed_q;
    assign winner_cnt  = win_cnt;

endmodule

// File: tb/tb_tone_classifier.sv
// Directed bench for tone_classifier (NUM_CH=5, DWELL=8, SYNC_STAGES=2, GAP=3, plus a GAP=0 instance).
// Edge k in each scenario is the k-th rising edge after the stimulus is first applied.
module tb_tone_classifier;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [4:0]  raw_tone;
    logic [4:0]  btn;
    logic [2:0]  tone_dir;
    logic        dir_valid;
    logic        dir_changed;
    logic [25:0] winner_cnt;

    logic [4:0]  raw_tone_g0;
    logic [4:0]  btn_g0;
    logic [2:0]  tone_dir_g0;
    logic        dir_valid_g0;
    logic        dir_changed_g0;
    logic [25:0] winner_cnt_g0;

    int n_cmp;
    int n_bad;

    tone_classifier #(
        .NUM_CH      (5),
        .DWELL       (8),
        .CNT_W       (26),
        .GAP         (3),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .raw_tone    (raw_tone),
        .btn         (btn),
        .tone_dir    (tone_dir),
        .dir_valid   (dir_valid),
        .dir_changed (dir_changed),
        .winner_cnt  (winner_cnt)
    );

    tone_classifier #(
        .NUM_CH      (5),
        .DWELL       (8),
        .CNT_W       (26),
        .GAP         (0),
        .SYNC_STAGES (2)
    ) u_dut_g0 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .raw_tone    (raw_tone_g0),
        .btn         (btn_g0),
        .tone_dir    (tone_dir_g0),
        .dir_valid   (dir_valid_g0),
        .dir_changed (dir_changed_g0),
        .winner_cnt  (winner_cnt_g0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        raw_tone    = '0;
        btn         = '0;
        raw_tone_g0 = '0;
        btn_g0      = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        enable   = 1'b1;
        raw_tone = 5'b11111;
        btn      = 5'b11111;
        tick();
        tick();
        tick();
        n_cmp++;
        if (tone_dir !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_tone_dir: got %0d want 0", tone_dir);
        end
        n_cmp++;
        if (dir_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dir_valid: got %0b want 0", dir_valid);
        end
        n_cmp++;
        if (dir_changed !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dir_changed: got %0b want 0", dir_changed);
        end
        n_cmp++;
        if (winner_cnt !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_winner_cnt: got %0d want 0", winner_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_hold_repeat();
        logic [2:0] exp_dir;
        logic       exp_v;
        logic       exp_c;
        do_reset();
        enable   = 1'b1;
        raw_tone = 5'b00100;
        for (int k = 1; k <= 19; k++) begin
            tick();
            exp_dir = (k >= 10) ? 3'd3 : 3'd0;
            exp_v   = (k == 10) || (k == 18);
            exp_c   = (k == 10);
            n_cmp++;
            if (tone_dir !== exp_dir) begin
                n_bad++;
                $display("FAIL hold_repeat_dir edge %0d: got %0d want %0d", k, tone_dir, exp_dir);
            end
            n_cmp++;
            if (dir_valid !== exp_v) begin
                n_bad++;
                $display("FAIL hold_repeat_valid edge %0d: got %0b want %0b", k, dir_valid, exp_v);
            end
            n_cmp++;
            if (dir_changed !== exp_c) begin
                n_bad++;
                $display("FAIL hold_repeat_changed edge %0d: got %0b want %0b", k, dir_changed, exp_c);
            end
        end
        $display("test_hold_repeat done");
    endtask

    task automatic test_preempt_resume();
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            raw_tone = (k == 6 || k == 7) ? 5'b00001 : 5'b00000;
            btn      = (k == 6 || k == 7) ? 5'b00000 : 5'b00010;
            tick();
            if (k == 8) begin
                n_cmp++;
                if (winner_cnt !== 26'd1) begin
                    n_bad++;
                    $display("FAIL preempt_ch0_cnt edge %0d: got %0d want 1", k, winner_cnt);
                end
            end
            if (k == 9) begin
                n_cmp++;
                if (winner_cnt !== 26'd5) begin
                    n_bad++;
                    $display("FAIL preempt_resume_cnt edge %0d: got %0d want 5", k, winner_cnt);
                end
            end
            n_cmp++;
            if (dir_valid !== (k == 12)) begin
                n_bad++;
                $display("FAIL preempt_valid edge %0d: got %0b want %0b", k, dir_valid, (k == 12));
            end
            if (k == 12) begin
                n_cmp++;
                if (tone_dir !== 3'd2 || dir_changed !== 1'b1) begin
                    n_bad++;
                    $display("FAIL preempt_commit edge %0d: got dir %0d chg %0b want dir 2 chg 1",
                             k, tone_dir, dir_changed);
                end
            end
        end
        $display("test_preempt_resume done");
    endtask

    task automatic test_gap_exceeded();
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            raw_tone = (k >= 6 && k <= 9) ? 5'b00001 : 5'b00000;
            btn      = (k >= 6 && k <= 9) ? 5'b00000 : 5'b00010;
            tick();
            if (k == 11) begin
                n_cmp++;
                if (winner_cnt !== 26'd0) begin
                    n_bad++;
                    $display("FAIL gap_clear_cnt edge %0d: got %0d want 0", k, winner_cnt);
                end
            end
            if (k == 12) begin
                n_cmp++;
                if (winner_cnt !== 26'd1) begin
                    n_bad++;
                    $display("FAIL gap_restart_cnt edge %0d: got %0d want 1", k, winner_cnt);
                end
            end
            n_cmp++;
            if (dir_valid !== (k == 19)) begin
                n_bad++;
                $display("FAIL gap_valid edge %0d: got %0b want %0b", k, dir_valid, (k == 19));
            end
        end
        n_cmp++;
        if (tone_dir !== 3'd2) begin
            n_bad++;
            $display("FAIL gap_final_dir: got %0d want 2", tone_dir);
        end
        $display("test_gap_exceeded done");
    endtask

    task automatic test_gap0_toggle();
        logic saw_one;
        saw_one = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            raw_tone_g0 = {k[0], 4'b0000};
            tick();
            if (u_dut_g0.cnt_q[4] == 26'd1) saw_one = 1'b1;
            n_cmp++;
            if (u_dut_g0.cnt_q[4] > 26'd1 || winner_cnt_g0 > 26'd1) begin
                n_bad++;
                $display("FAIL gap0_cnt edge %0d: got cnt %0d winner_cnt %0d want <= 1",
                         k, u_dut_g0.cnt_q[4], winner_cnt_g0);
            end
            n_cmp++;
            if (dir_valid_g0 !== 1'b0) begin
                n_bad++;
                $display("FAIL gap0_valid edge %0d: got %0b want 0", k, dir_valid_g0);
            end
        end
        n_cmp++;
        if (saw_one !== 1'b1 || tone_dir_g0 !== 3'd0) begin
            n_bad++;
            $display("FAIL gap0_summary: got saw_one %0b dir %0d want 1 and 0", saw_one, tone_dir_g0);
        end
        raw_tone_g0 = '0;
        $display("test_gap0_toggle done");
    endtask

    task automatic test_all_channels();
        do_reset();
        enable   = 1'b1;
        raw_tone = 5'b11111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            for (int j = 1; j < 5; j++) begin
                n_cmp++;
                if (u_dut.cnt_q[j] !== 26'd0) begin
                    n_bad++;
                    $display("FAIL all_ch_low_cnt edge %0d ch %0d: got %0d want 0", k, j, u_dut.cnt_q[j]);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (winner_cnt !== 26'd3) begin
                    n_bad++;
                    $display("FAIL all_ch_winner_cnt edge %0d: got %0d want 3", k, winner_cnt);
                end
            end
            n_cmp++;
            if (dir_valid !== (k == 10)) begin
                n_bad++;
                $display("FAIL all_ch_valid edge %0d: got %0b want %0b", k, dir_valid, (k == 10));
            end
        end
        n_cmp++;
        if (tone_dir !== 3'd1) begin
            n_bad++;
            $display("FAIL all_ch_dir: got %0d want 1", tone_dir);
        end
        $display("test_all_channels done");
    endtask

    task automatic test_disable_on_commit();
        logic [2:0] exp_dir;
        do_reset();
        raw_tone = 5'b00100;
        for (int k = 1; k <= 21; k++) begin
            enable = (k != 10) && (k < 20);
            tick();
            if (k == 9) begin
                n_cmp++;
                if (winner_cnt !== 26'd7) begin
                    n_bad++;
                    $display("FAIL dis_pre_cnt edge %0d: got %0d want 7", k, winner_cnt);
                end
            end
            if (k == 10) begin
                n_cmp++;
                if (winner_cnt !== 26'd0) begin
                    n_bad++;
                    $display("FAIL dis_cleared_cnt edge %0d: got %0d want 0", k, winner_cnt);
                end
            end
            exp_dir = (k == 18 || k == 19) ? 3'd3 : 3'd0;
            n_cmp++;
            if (tone_dir !== exp_dir) begin
                n_bad++;
                $display("FAIL dis_dir edge %0d: got %0d want %0d", k, tone_dir, exp_dir);
            end
            n_cmp++;
            if (dir_valid !== (k == 18) || dir_changed !== (k == 18)) begin
                n_bad++;
                $display("FAIL dis_pulses edge %0d: got valid %0b chg %0b want %0b %0b",
                         k, dir_valid, dir_changed, (k == 18), (k == 18));
            end
        end
        enable = 1'b1;
        $display("test_disable_on_commit done");
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        enable   = 1'b1;
        raw_tone = 5'b00100;
        for (int k = 1; k <= 20; k++) begin
            rst = (k == 9);
            tick();
            if (k == 8) begin
                n_cmp++;
                if (winner_cnt !== 26'd6) begin
                    n_bad++;
                    $display("FAIL rst_pre_cnt edge %0d: got %0d want 6", k, winner_cnt);
                end
            end
            if (k == 9) begin
                n_cmp++;
                if (u_dut.cnt_q[2] !== 26'd0 || winner_cnt !== 26'd0) begin
                    n_bad++;
                    $display("FAIL rst_cleared edge %0d: got cnt %0d winner_cnt %0d want 0 0",
                             k, u_dut.cnt_q[2], winner_cnt);
                end
            end
            n_cmp++;
            if (dir_valid !== (k == 19)) begin
                n_bad++;
                $display("FAIL rst_valid edge %0d: got %0b want %0b", k, dir_valid, (k == 19));
            end
            n_cmp++;
            if (tone_dir !== ((k >= 19) ? 3'd3 : 3'd0)) begin
                n_bad++;
                $display("FAIL rst_dir edge %0d: got %0d want %0d", k, tone_dir, (k >= 19) ? 3 : 0);
            end
        end
        rst = 1'b0;
        $display("test_reset_mid_count done");
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        enable      = 1'b0;
        raw_tone    = '0;
        btn         = '0;
        raw_tone_g0 = '0;
        btn_g0      = '0;
        test_reset();
        test_hold_repeat();
        test_preempt_resume();
        test_gap_exceeded();
        test_gap0_toggle();
        test_all_channels();
        test_disable_on_commit();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
